pce_rom_loader: RTL and testbench

Sequencer between the HPS download stream and the two ROM memory backends (SDRAM and DDR3). It takes 16-bit words from the ioctl interface and applies the optional ROM bit-swap. It issues one toggle-handshake write per word to both backends, holds ioctl_wait until both have acknowledged, and advances the write address. It also derives the cart metadata the PCE core needs: ROM size, 512-byte header presence, SuperGrafx flag and Populous detection.

---
 rtl/pce_loader_pkg.sv | 40 ++++
 rtl/pce_populous_detect.sv | 48 ++++
 rtl/pce_rom_loader.sv | 141 ++++++++++++++
 tb/tb_pce_rom_loader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pce_loader_pkg.sv
// Shared types and constants for the PCE ROM loader.
// Populous signature constants exist only when POPULOUS_DETECT_EN is defined.
package pce_loader_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned SGX_W  = 5;

  localparam logic [IDX_W-1:0] DEF_CODE_INDEX = 8'hFF;
  localparam logic [SGX_W-1:0] DEF_SGX_INDEX  = 5'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PEND = 2'd2
  } state_t;

`ifdef POPULOUS_DETECT_EN
  // Signature words at offsets 6/8/10/12 inside each 16-byte window.
  localparam logic [DATA_W-1:0] POP_SIG_6  = 16'h4F50;
  localparam logic [DATA_W-1:0] POP_SIG_8  = 16'h5550;
  localparam logic [DATA_W-1:0] POP_SIG_10 = 16'h4F4C;
  localparam logic [DATA_W-1:0] POP_SIG_12 = 16'h5355;
  localparam logic [19:0]       POP_BLK_LO = 20'h1F2;
  localparam logic [19:0]       POP_BLK_HI = 20'h212;
`endif

  // Reverse bit order inside each byte; byte order is preserved.
  function automatic logic [DATA_W-1:0] bitrev_bytes(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pce_populous_detect.sv
// Populous signature checker: one flag per ROM bank, cleared on any mismatching signature word.
// Built only when POPULOUS_DETECT_EN is defined.
`ifdef POPULOUS_DETECT_EN
module pce_populous_detect
  import pce_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        accept,
  input  logic [23:0] addr,
  input  logic [15:0] data,
  output logic [1:0]  flags
);

  logic [DATA_W-1:0] expect_c;
  logic              sig_slot_c;
  logic              in_window_c;
  logic              miss_c;

  // Map the word offset inside the window to its signature word.
  always_comb begin
    expect_c   = '0;
    sig_slot_c = 1'b0;
    case (addr[3:0])
      4'd6:    begin expect_c = POP_SIG_6;  sig_slot_c = 1'b1; end
      4'd8:    begin expect_c = POP_SIG_8;  sig_slot_c = 1'b1; end
      4'd10:   begin expect_c = POP_SIG_10; sig_slot_c = 1'b1; end
      4'd12:   begin expect_c = POP_SIG_12; sig_slot_c = 1'b1; end
      default: begin expect_c = '0;         sig_slot_c = 1'b0; end
    endcase
  end

  assign in_window_c = (addr[23:4] == POP_BLK_LO) || (addr[23:4] == POP_BLK_HI);
  assign miss_c      = accept && in_window_c && sig_slot_c && (data != expect_c);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      flags <= 2'b11;
    end else if (start) begin
      flags <= 2'b11;
    end else if (miss_c) begin
      flags[addr[13]] <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/pce_rom_loader.sv
// HPS download stream to SDRAM/DDR3 toggle-handshake writer, plus PCE cart metadata.
// Define POPULOUS_DETECT_EN to build the Populous signature detector.
module pce_rom_loader
  import pce_loader_pkg::*;
#(
  parameter logic [7:0] CODE_INDEX = DEF_CODE_INDEX,
  parameter logic [4:0] SGX_INDEX  = DEF_SGX_INDEX
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic        swap_en,
  output logic        rom_wr,
  output logic [23:0] romwr_a,
  output logic [15:0] romwr_d,
  input  logic        sd_wrack,
  input  logic        dd_wrack,
  output logic        cart_download,
  output logic [7:0]  rom_sz,
  output logic        hdr512,
  output logic [1:0]  populous,
  output logic        sgx,
  output logic        overrun
);

  state_t            state_q, state_d;
  logic              dl_q;
  logic              wait_q, wait_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sgx_q, sgx_d;
  logic              ovr_q, ovr_d;

  logic              start_c;
  logic              accept_c;
  logic              ack_c;
  logic [DATA_W-1:0] word_sw_c;

  assign cart_download = ioctl_download & (ioctl_index != CODE_INDEX);
  assign start_c       = (state_q == IDLE) & cart_download & ~dl_q;
  assign accept_c      = (state_q == ARM) & cart_download & ioctl_wr;
  assign ack_c         = (wr_q == sd_wrack) & (wr_q == dd_wrack);
  assign word_sw_c     = swap_en ? bitrev_bytes(ioctl_dout) : ioctl_dout;

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sgx_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= cart_download;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sgx_q   <= sgx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sgx_d   = sgx_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = ARM;
          addr_d  = '0;
          ovr_d   = 1'b0;
          sgx_d   = (ioctl_index[4:0] == SGX_INDEX);
        end
      end
      ARM: begin
        if (!cart_download) begin
          state_d = IDLE;
        end else if (accept_c) begin
          data_d  = word_sw_c;
          wr_d    = ~wr_q;
          wait_d  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        // A strobe while stalled is dropped and remembered.
        if (ioctl_wr) begin
          ovr_d = 1'b1;
        end
        if (ack_c) begin
          wait_d  = 1'b0;
          addr_d  = addr_q + 24'd2;
          state_d = cart_download ? ARM : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ioctl_wait = wait_q;
  assign rom_wr     = wr_q;
  assign romwr_a    = addr_q;
  assign romwr_d    = data_q;
  assign sgx        = sgx_q;
  assign overrun    = ovr_q;
  assign rom_sz     = addr_q[23:16];
  assign hdr512     = addr_q[9];

`ifdef POPULOUS_DETECT_EN
  pce_populous_detect u_populous (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start_c),
    .accept  (accept_c),
    .addr    (addr_q),
    .data    (word_sw_c),
    .flags   (populous)
  );
`else
  assign populous = 2'b00;
`endif

endmodule

// File: tb/tb_pce_rom_loader.sv
// Self-checking bench for pce_rom_loader: vector table, directed corner cases and randomized downloads.
`timescale 1ns/1ps
module tb_pce_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        swap_en;
  logic        rom_wr;
  logic [23:0] romwr_a;
  logic [15:0] romwr_d;
  logic        sd_wrack;
  logic        dd_wrack;
  logic        cart_download;
  logic [7:0]  rom_sz;
  logic        hdr512;
  logic [1:0]  populous;
  logic        sgx;
  logic        overrun;

`ifdef POPULOUS_DETECT_EN
  localparam logic [1:0] POP_RST = 2'b11;
  localparam bit         POP_ON  = 1'b1;
`else
  localparam logic [1:0] POP_RST = 2'b00;
  localparam bit         POP_ON  = 1'b0;
`endif
  localparam logic [15:0] SIGS [4] = '{16'h4F50, 16'h5550, 16'h4F4C, 16'h5355};

  pce_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .swap_en        (swap_en),
    .rom_wr         (rom_wr),
    .romwr_a        (romwr_a),
    .romwr_d        (romwr_d),
    .sd_wrack       (sd_wrack),
    .dd_wrack       (dd_wrack),
    .cart_download  (cart_download),
    .rom_sz         (rom_sz),
    .hdr512         (hdr512),
    .populous       (populous),
    .sgx            (sgx),
    .overrun        (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  int sd_dly = 0, dd_dly = 0, sd_cnt, dd_cnt;
  logic        prev_wr;
  logic [23:0] cap_a [$];
  logic [15:0] cap_d [$];
  logic [15:0] exp_d [$];
  logic [15:0] mem [int];

  // Backend models: answer a toggle after a programmable number of cycles.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_wrack <= 1'b0;
      sd_cnt   <= 0;
    end else if (rom_wr != sd_wrack) begin
      if (sd_cnt >= sd_dly) begin
        sd_wrack <= rom_wr;
        sd_cnt   <= 0;
      end else begin
        sd_cnt <= sd_cnt + 1;
      end
    end
  end

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dd_wrack <= 1'b0;
      dd_cnt   <= 0;
    end else if (rom_wr != dd_wrack) begin
      if (dd_cnt >= dd_dly) begin
        dd_wrack <= rom_wr;
        dd_cnt   <= 0;
      end else begin
        dd_cnt <= dd_cnt + 1;
      end
    end
  end

  // Record address/data seen by the backends at every write toggle.
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_wr = 1'b0;
    end else if (rom_wr !== prev_wr) begin
      cap_a.push_back(romwr_a);
      cap_d.push_back(romwr_d);
      prev_wr = rom_wr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] swap_model(input logic [15:0] w);
    logic [7:0] hi, lo, rh, rl;
    hi = w[15:8];
    lo = w[7:0];
    rh = {<<{hi}};
    rl = {<<{lo}};
    return {rh, rl};
  endfunction

  // Bank b is intact when every signature slot written in its window matches.
  function automatic logic [1:0] pop_model();
    logic [1:0] f;
    f = POP_RST;
    if (POP_ON) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          int a;
          a = (b == 1 ? 'h2120 : 'h1F20) + 6 + 2 * k;
          if (mem.exists(a) && mem[a] != SIGS[k]) f[b] = 1'b0;
        end
      end
    end
    return f;
  endfunction

  task automatic clear_caps();
    cap_a.delete();
    cap_d.delete();
    exp_d.delete();
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic s);
    ioctl_index    = idx;
    swap_en        = s;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  // One word; optional second strobe while stalled; returns cycles ioctl_wait was high.
  task automatic send_word(input logic [15:0] w, input bit extra, output int wc);
    ioctl_dout = w;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    wc       = 0;
    ioctl_wr = extra;
    while (ioctl_wait && wc < 100) begin
      wc++;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
    end
    ioctl_wr = 1'b0;
    check("wait_release", 32'(ioctl_wait), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
    check({tag, "_rom_wr"}, 32'(rom_wr), 32'd0);
    check({tag, "_addr"}, 32'(romwr_a), 32'd0);
    check({tag, "_data"}, 32'(romwr_d), 32'd0);
    check({tag, "_populous"}, 32'(populous), 32'(POP_RST));
    check({tag, "_sgx"}, 32'(sgx), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  idx;
    logic        swap;
    logic [15:0] dout;
    logic [15:0] exp_d;
    logic        exp_sgx;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    logic [7:0] idx_opts [4];

    vecs[0] = '{8'h02, 1'b1, 16'h0180, 16'h8001, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 16'h1234, 16'h1234, 1'b0};
    vecs[2] = '{8'h42, 1'b1, 16'hF00F, 16'h0FF0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 16'h1248, 16'h4812, 1'b0};
    vecs[4] = '{8'h03, 1'b0, 16'hA5C3, 16'hA5C3, 1'b0};
    idx_opts = '{8'h01, 8'h02, 8'h03, 8'h22};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_dout = 16'h0000;
    swap_en = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk_sys);

    // Four-word download, acks three cycles after each toggle.
    clear_caps();
    sd_dly = 2; dd_dly = 2;
    start_dl(8'h01, 1'b0);
    check("t1_cart_download", 32'(cart_download), 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      exp_d.push_back(w);
      send_word(w, 1'b0, wc);
      check("t1_wait_cycles", 32'(wc), 32'd4);
    end
    end_dl();
    check("t1_toggles", 32'(cap_a.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      check("t1_addr", 32'(cap_a[i]), 32'(2 * i));
      check("t1_data", 32'(cap_d[i]), 32'(exp_d[i]));
    end
    check("t1_end_addr", 32'(romwr_a), 32'd8);
    check("t1_sgx", 32'(sgx), 32'd0);
    check("t1_rom_sz", 32'(rom_sz), 32'd0);
    check("t1_rom_wr", 32'(rom_wr), 32'd0);

    // Single-word downloads from the vector table.
    sd_dly = 1; dd_dly = 0;
    for (int v = 0; v < 5; v++) begin
      clear_caps();
      start_dl(vecs[v].idx, vecs[v].swap);
      send_word(vecs[v].dout, 1'b0, wc);
      end_dl();
      check("vec_data", 32'(romwr_d), 32'(vecs[v].exp_d));
      check("vec_sgx", 32'(sgx), 32'(vecs[v].exp_sgx));
      check("vec_addr", 32'(romwr_a), 32'd2);
      check("vec_toggles", 32'(cap_a.size()), 32'd1);
      check("vec_model", 32'(vecs[v].exp_d), 32'(vecs[v].swap ? swap_model(vecs[v].dout) : vecs[v].dout));
    end

    // Cheat-code stream is ignored.
    clear_caps();
    ioctl_index = 8'hFF;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("code_cart_download", 32'(cart_download), 32'd0);
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (3) begin
      check("code_wait", 32'(ioctl_wait), 32'd0);
      @(negedge clk_sys);
    end
    end_dl();
    check("code_toggles", 32'(cap_a.size()), 32'd0);
    check("code_addr", 32'(romwr_a), 32'd2);

    // Acks in either order or together.
    start_dl(8'h01, 1'b0);
    sd_dly = 0; dd_dly = 5;
    send_word(16'h1111, 1'b0, wc);
    check("split_sd_first", 32'(wc), 32'd7);
    sd_dly = 5; dd_dly = 0;
    send_word(16'h2222, 1'b0, wc);
    check("split_dd_first", 32'(wc), 32'd7);
    sd_dly = 1; dd_dly = 1;
    send_word(16'h3333, 1'b0, wc);
    check("split_same", 32'(wc), 32'd3);
    end_dl();
    check("split_addr", 32'(romwr_a), 32'd6);

    // Strobe during stall is dropped and flagged.
    clear_caps();
    sd_dly = 3; dd_dly = 3;
    start_dl(8'h01, 1'b0);
    send_word(16'h5A5A, 1'b1, wc);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_toggles", 32'(cap_a.size()), 32'd1);
    check("ovr_addr", 32'(romwr_a), 32'd2);
    check("ovr_data", 32'(romwr_d), 32'h5A5A);
    end_dl();
    check("ovr_sticky", 32'(overrun), 32'd1);
    start_dl(8'h01, 1'b0);
    check("ovr_cleared", 32'(overrun), 32'd0);
    end_dl();

    // Reset in the middle of a pending write.
    sd_dly = 8; dd_dly = 8;
    start_dl(8'h02, 1'b1);
    send_word(16'h0F0F, 1'b0, wc);
    send_word(16'h1234, 1'b0, wc);
    ioctl_dout = 16'h00FF;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("rst_pend_wait", 32'(ioctl_wait), 32'd1);
    #2;
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    clear_caps();
    sd_dly = 1; dd_dly = 1;
    start_dl(8'h01, 1'b0);
    send_word(16'hBEEF, 1'b0, wc);
    end_dl();
    check("rst_new_toggles", 32'(cap_a.size()), 32'd1);
    if (cap_a.size() > 0) check("rst_new_addr0", 32'(cap_a[0]), 32'd0);
    check("rst_new_sgx", 32'(sgx), 32'd0);

    // Long download crossing both Populous windows.
    mem.delete();
    sd_dly = 0; dd_dly = 0;
    start_dl(8'h01, 1'b0);
    for (int a = 0; a <= 'h2130; a += 2) begin
      logic [15:0] w;
      if (a >= 'h1F26 && a <= 'h1F2C) w = SIGS[(a - 'h1F26) / 2];
      else if (a >= 'h2126 && a <= 'h212A) w = SIGS[(a - 'h2126) / 2];
      else if (a == 'h212C) w = 16'hDEAD;
      else w = 16'($urandom);
      mem[a] = w;
      send_word(w, 1'b0, wc);
      check("pop_hdr512", 32'(hdr512), 32'(((a + 2) / 512) % 2));
      check("pop_rom_sz", 32'(rom_sz), 32'((a + 2) / 65536));
    end
    end_dl();
    check("pop_end_addr", 32'(romwr_a), 32'h2132);
    check("pop_flags", 32'(populous), 32'(pop_model()));
    check("pop_flags_const", 32'(populous), POP_ON ? 32'h1 : 32'h0);

    // Randomized downloads against the word-stream model.
    for (int d = 0; d < 4; d++) begin
      logic [7:0] idx;
      logic       s;
      bit         any_extra;
      int         n;
      clear_caps();
      idx = idx_opts[$urandom_range(0, 3)];
      s = 1'($urandom_range(0, 1));
      n = $urandom_range(10, 30);
      any_extra = 1'b0;
      start_dl(idx, s);
      for (int k = 0; k < n; k++) begin
        logic [15:0] w;
        bit ex;
        w = 16'($urandom);
        ex = ($urandom_range(0, 7) == 0);
        any_extra |= ex;
        sd_dly = $urandom_range(0, 5);
        dd_dly = $urandom_range(0, 5);
        exp_d.push_back(s ? swap_model(w) : w);
        send_word(w, ex, wc);
        check("rnd_wait_cycles", 32'(wc), 32'(((sd_dly > dd_dly) ? sd_dly : dd_dly) + 2));
      end
      end_dl();
      check("rnd_toggles", 32'(cap_a.size()), 32'(n));
      for (int i = 0; i < n && i < cap_a.size(); i++) begin
        check("rnd_addr", 32'(cap_a[i]), 32'(2 * i));
        check("rnd_data", 32'(cap_d[i]), 32'(exp_d[i]));
      end
      check("rnd_end_addr", 32'(romwr_a), 32'(2 * n));
      check("rnd_overrun", 32'(overrun), 32'(any_extra));
      check("rnd_sgx", 32'(sgx), 32'(idx % 32 == 2));
      check("rnd_populous", 32'(populous), 32'(POP_RST));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
